// File: rtl/candle_flicker_gen_if.sv
// Control and brightness bundle between the flicker generator and its host.
// The host drives enable, mode and update period; the generator returns the
// update pulse and the brightness code for the PWM stage.
interface candle_flicker_gen_if #(
    parameter int DIV_W = 16,
    parameter int OUT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [OUT_W-1:0] brightness;

    modport master (
        output en,
        output mode,
        output div,
        input  tick,
        input  brightness
    );

    modport slave (
        input  en,
        input  mode,
        input  div,
        output tick,
        output brightness
    );
endinterface

// File: rtl/candle_flicker_gen.sv
// Candle flicker brightness generator.
// A 16-bit LFSR feeds N saturating random-walk taps that move once per
// prescaler tick; their sum on top of a base level gives the flicker target.
// A small mode FSM selects dark, steady, flicker or a fade-in ramp that climbs
// one code per tick until it meets the flicker target.
module candle_flicker_gen #(
    parameter int          N_TAPS    = 3,
    parameter int          TAP_MAX   = 64,
    parameter int          BASE      = 64,
    parameter int          OUT_W     = 8,
    parameter int          DIV_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                clk,
    input logic                rst_n,
    candle_flicker_gen_if.slave bus
);

    localparam int               TAP_W      = $clog2(TAP_MAX + 1);
    localparam logic [TAP_W-1:0] TAP_TOP    = TAP_W'(TAP_MAX);
    localparam logic [31:0]      OUT_MAX_W  = 32'((1 << OUT_W) - 1);
    localparam logic [31:0]      STEADY_RAW = 32'(BASE + (N_TAPS * TAP_MAX) / 2);
    localparam logic [OUT_W-1:0] STEADY_V   = (STEADY_RAW > OUT_MAX_W) ?
                                              OUT_MAX_W[OUT_W-1:0] :
                                              STEADY_RAW[OUT_W-1:0];

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_STEADY = 2'd1,
        S_RUN    = 2'd2,
        S_RAMP   = 2'd3
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [DIV_W-1:0] cnt;
    logic [TAP_W-1:0] taps [N_TAPS];
    logic             tick_q;
    logic [OUT_W-1:0] bright_q;
    logic [31:0]      sum;
    logic [OUT_W-1:0] target;
    logic             fire;

    // A lowered div leaves cnt above it; treating that as the end of the
    // period keeps the prescaler from running the long way round.
    assign fire = bus.en && (cnt >= bus.div);

    assign bus.tick       = tick_q;
    assign bus.brightness = bright_q;

    // Full-width tap sum on top of the base level, clamped to the output range.
    always_comb begin
        sum = 32'(BASE);
        for (int i = 0; i < N_TAPS; i++) begin
            sum = sum + 32'(taps[i]);
        end
        target = (sum > OUT_MAX_W) ? OUT_MAX_W[OUT_W-1:0] : sum[OUT_W-1:0];
    end

    // Fibonacci LFSR advancing on every enabled cycle, recovering from all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (bus.en) begin
            if (lfsr == 16'd0) begin
                lfsr <= LFSR_SEED;
            end else begin
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
        end
    end

    // Update-rate prescaler producing a registered one-cycle tick per period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= fire;
            if (bus.en) begin
                cnt <= fire ? '0 : cnt + 1'b1;
            end
        end
    end

    // Random-walk taps: each steps up or down on its own LFSR bit, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                taps[i] <= '0;
            end
        end else if (bus.en) begin
            if (bus.mode == 2'b00) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    taps[i] <= '0;
                end
            end else if (bus.mode[1] && fire) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    if (lfsr[i]) begin
                        if (taps[i] < TAP_TOP) taps[i] <= taps[i] + 1'b1;
                    end else begin
                        if (taps[i] != '0) taps[i] <= taps[i] - 1'b1;
                    end
                end
            end
        end
    end

    // Mode FSM; the mode seen on an edge decides that edge's brightness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_OFF;
            bright_q <= '0;
        end else if (bus.en) begin
            case (bus.mode)
                2'b00: begin
                    state    <= S_OFF;
                    bright_q <= '0;
                end
                2'b01: begin
                    state    <= S_STEADY;
                    bright_q <= STEADY_V;
                end
                2'b10: begin
                    state    <= S_RUN;
                    bright_q <= target;
                end
                default: begin
                    case (state)
                        S_RUN: begin
                            bright_q <= target;
                        end
                        S_RAMP: begin
                            if (bright_q >= target) begin
                                state    <= S_RUN;
                                bright_q <= target;
                            end else if (fire) begin
                                bright_q <= bright_q + 1'b1;
                            end
                        end
                        default: begin
                            state <= S_RAMP;
                            if (fire && (bright_q < target)) begin
                                bright_q <= bright_q + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
